// File: rtl/button_press_blink_if.sv
// Signal bundle between the synchronised push-button source, the press tracker and the LED driver.
interface button_press_blink_if;
  logic       button;
  logic       blink;
  logic [1:0] q;
  logic [1:0] qbar;

  modport master (
    output button,
    input  blink,
    input  q,
    input  qbar
  );

  modport slave (
    input  button,
    output blink,
    output q,
    output qbar
  );
endinterface

// File: rtl/button_press_blink.sv
// Two-bit press counter advanced on each rising edge of a pre-synchronised button; blink follows q[0].
module button_press_blink (
  input  logic                clk,
  input  logic                rst_n,
  button_press_blink_if.slave btn_if
);

  typedef enum logic [1:0] {
    CNT0 = 2'b00,
    CNT1 = 2'b01,
    CNT2 = 2'b10,
    CNT3 = 2'b11
  } state_t;

  state_t state;
  state_t state_nx;
  logic   btn_prev;
  logic   press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CNT0;
      btn_prev <= 1'b0;
    end else begin
      state    <= state_nx;
      btn_prev <= btn_if.button;
    end
  end

  // Enum walk is the d0 = q0^press, d1 = q1^(q0&press) counter with 11 wrapping to 00.
  always_comb begin
    press    = btn_if.button & ~btn_prev;
    state_nx = state;
    if (press) begin
      case (state)
        CNT0:    state_nx = CNT1;
        CNT1:    state_nx = CNT2;
        CNT2:    state_nx = CNT3;
        CNT3:    state_nx = CNT0;
        default: state_nx = CNT0;
      endcase
    end
  end

  assign btn_if.q     = state;
  assign btn_if.qbar  = ~state;
  assign btn_if.blink = state[0];

endmodule

// File: tb/tb_button_press_blink.sv
// Directed bench for button_press_blink; expected states are queued and checked by a separate monitor.
module tb_button_press_blink;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [1:0] exp_q[$];
  string      name_q[$];
  event       smp;

  button_press_blink_if bif ();

  button_press_blink dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_if (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string nm, input logic [1:0] act, input logic [1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every sample strobe drains the queued expectations against the live outputs.
  initial begin
    logic [1:0] e;
    string      nm;
    forever begin
      @(smp);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check_bit({nm, ".q"},     bif.q,              e);
        check_bit({nm, ".qbar"},  bif.qbar,           ~e);
        check_bit({nm, ".blink"}, {1'b0, bif.blink},  {1'b0, e[0]});
      end
    end
  end

  task automatic expect_now(input string nm, input logic [1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> smp;
  endtask

  task automatic step(input string nm, input logic b, input logic [1:0] e);
    @(negedge clk);
    bif.button = b;
    @(posedge clk);
    #1;
    expect_now(nm, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bif.button = 1'b0;
    rst_n      = 1'b0;
    #1;
    expect_now("rst_pulse", 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic       dir_b[13] = '{1,0,1,1,1,0,0,1,0,0,0,1,0};
  logic [1:0] dir_e[13] = '{2'b01,2'b01,2'b10,2'b10,2'b10,2'b10,2'b10,
                            2'b11,2'b11,2'b11,2'b11,2'b00,2'b00};
  logic       wrap_b[7] = '{1,0,1,0,1,0,1};
  logic [1:0] wrap_e[7] = '{2'b01,2'b01,2'b10,2'b10,2'b11,2'b11,2'b00};

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bif.button = 1'b1;

    // Reset held with button high, then released with button still high.
    #2;
    expect_now("rst_initial", 2'b00);
    @(posedge clk); #1; expect_now("rst_hold1", 2'b00);
    @(posedge clk); #1; expect_now("rst_hold2", 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1; expect_now("rst_release_press", 2'b01);

    do_reset();
    for (int i = 0; i < 13; i++) step($sformatf("dir%0d", i), dir_b[i], dir_e[i]);

    do_reset();
    for (int i = 0; i < 8; i++) step($sformatf("held%0d", i), 1'b1, 2'b01);
    step("held_release", 1'b0, 2'b01);

    do_reset();
    for (int i = 0; i < 7; i++) step($sformatf("wrap%0d", i), wrap_b[i], wrap_e[i]);

    // Asynchronous reset pulse while q = 11.
    do_reset();
    for (int i = 0; i < 5; i++) step($sformatf("pre_async%0d", i), wrap_b[i], wrap_e[i]);
    step("pre_async_low", 1'b0, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    expect_now("async_immediate", 2'b00);
    #1;
    rst_n = 1'b1;
    step("async_idle", 1'b0, 2'b00);
    step("async_resume", 1'b1, 2'b01);
    step("async_release", 1'b0, 2'b01);

    // 3-unit glitch wholly between rising edges.
    #1;
    bif.button = 1'b1;
    #2;
    expect_now("glitch_during", 2'b01);
    #1;
    bif.button = 1'b0;
    @(posedge clk); #1; expect_now("glitch_after", 2'b01);
    step("glitch_press", 1'b1, 2'b10);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/button_press_blink.md
Name: button_press_blink

Overview:
- Synchronous button-press tracker driving an LED blink output.
- Built from two D flip-flops that hold a 2-bit press-count state `q`. A third internal flop holds the previous button sample for rising-edge detection.
- Each new press (button 0->1 between samples) advances the state by one, modulo 4.
- `blink` mirrors `q[0]`, so the LED toggles on every press. Sits between a pre-synchronised push-button input and an LED driver.

Parameters:
None. State width is fixed at 2 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- button  input  1  push-button level, already synchronised to clk, active-high
- blink  output  1  LED drive; equals q[0]
- q  output  2  current press-count state (ff1 = q[1], ff0 = q[0])
- qbar  output  2  bitwise complement of q

Behaviour:
- Reset:
  - rst_n low asynchronously forces q = 2'b00, qbar = 2'b11, blink = 0 and btn_prev = 0. This takes effect immediately, without waiting for a clock edge.
  - State is held while rst_n is low.
  - After rst_n deasserts, the first rising edge of clk samples normally.
- State elements, all updated on rising edge of clk: ff0 (q[0]), ff1 (q[1]), btn_prev.
- Press detection:
  - press = button & ~btn_prev, evaluated with the button value sampled at the current edge.
  - btn_prev <= button every edge.
- Next state:
  - If press: q <= q + 1 (2'b11 wraps to 2'b00).
  - Otherwise q holds.
  - As flop equations: d0 = q[0] ^ press; d1 = q[1] ^ (q[0] & press).
- Latency: q, qbar and blink change on the same rising edge at which button is first sampled high after being sampled low.
- Hold: button high across consecutive edges increments only once.
- Release: button low has no effect on q.
- Re-press after release: a low-to-high transition needs at least one edge with button sampled low in between.
- Single-edge pulse: button high for exactly one sampled edge counts as one press.
- Glitches: pulses that do not span a rising edge are ignored. The input is sampled, not edge-triggered.
- Outputs are combinational functions of the flop outputs only (Moore), so they are glitch-free with respect to button:
  - qbar = ~q at all times, including during reset.
  - blink = q[0].
- Reset in the middle of a held press: after release of reset, btn_prev = 0. If button is still high at the first edge, that counts as a new press (q becomes 01).
- No X propagation: all flops are reset. Outputs are defined from reset onward.

Test Plan:
- Reset:
  - Hold rst_n low for 2 cycles with button = 1 -> q = 00, qbar = 11, blink = 0 throughout.
  - Deassert rst_n with button = 1 at the next edge -> q = 01, blink = 1.
- Directed sequence: 10 ns clock, button changed midway between edges. Per-edge samples: 1,0,1,1,1,0,0,1,0,0,0,1,0.
  - Expected q after each edge: 01,01,10,10,10,10,10,11,11,11,11,00,00.
  - blink after each edge: 1,1,0,0,0,0,0,1,1,1,1,0,0.
  - qbar is always ~q.
- Held press: button high for 8 consecutive edges from q = 00 -> q = 01 after the first edge and stays 01.
- Wrap-around: four isolated presses from reset -> q steps 01, 10, 11, 00; blink sequence 1, 0, 1, 0.
- Asynchronous reset mid-count:
  - With q = 11, pulse rst_n low between clock edges -> q = 00, blink = 0 immediately, before the next edge.
  - The count then resumes from 00 on the next press.
- Sub-cycle glitch: a button pulse of 3 ns placed entirely between rising edges -> no change in q, qbar or blink.
